// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 access
// encodings, and the RV32 load/store opcodes that control_unit decodes.
// Also provides a helper that decides whether a funct3 is legal for a load or a store.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // funct3 access size / sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Major opcodes control_unit uses to raise mem_read / mem_write
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Unsigned variants only exist for loads; 011/110/111 never exist.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: byte-lane steering for the load/store unit (purely combinational).
// Ports: funct3_i/off_i select size and lane; store_data_i -> be_o/wdata_o;
//        rdata_i -> ld_data_o (selected lane, sign- or zero-extended).
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] rd_shifted;

    // Store side: funct3[1:0] is the size (00 byte, 01 half, 10 word).
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    assign rd_shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        ld_data_o = rd_shifted;
        case (funct3_i)
            F3_B:    ld_data_o = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_BU:   ld_data_o = {24'h0, rd_shifted[7:0]};
            F3_H:    ld_data_o = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_HU:   ld_data_o = {16'h0, rd_shifted[15:0]};
            default: ld_data_o = rd_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding-op LSU between execute stage and data memory.
// Ports: req_valid/req_ready + mem_read/mem_write/funct3/addr/store_data in;
//        dm_* request/ack to memory; rsp_valid/load_data/fault back to the pipeline.
// FSM IDLE->ACCESS->RESP; ACCESS times out after TIMEOUT_CYC cycles without dm_ack.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses;
// otherwise the misaligned low address bits are cleared and the access proceeds.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        rsp_valid,
    output logic [31:0] load_data,
    output logic        fault
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    lsu_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          req_ready_q;
    logic          dm_req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   sdata_q;
    logic          rsp_valid_q;
    logic          fault_q;
    logic [31:0]   load_data_q;

    // Request decode (IDLE only)
    logic [31:0] addr_d;
    logic        misaligned;
    logic        trap;
    logic        op_illegal;

    always_comb begin
        addr_d     = addr;
        misaligned = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            misaligned = addr[0];
            addr_d[0]  = 1'b0;
        end else if (funct3[1:0] == 2'b10) begin
            misaligned  = |addr[1:0];
            addr_d[1:0] = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned;
`else
    assign trap = 1'b0;
`endif

    assign op_illegal = (mem_read && mem_write) || !f3_legal(funct3, mem_write) || trap;

    // Lane steering works from the latched request so dm_* stay stable in ACCESS.
    logic [3:0]  be_w;
    logic [31:0] wdata_w;
    logic [31:0] ld_w;

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .off_i        (addr_q[1:0]),
        .store_data_i (sdata_q),
        .rdata_i      (dm_rdata),
        .be_o         (be_w),
        .wdata_o      (wdata_w),
        .ld_data_o    (ld_w)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            dm_req_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= '0;
            sdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (!mem_read && !mem_write) begin
                            // No memory op: complete immediately, no bus traffic.
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            fault_q     <= 1'b0;
                            load_data_q <= '0;
                        end else if (op_illegal) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            fault_q     <= 1'b1;
                            load_data_q <= '0;
                        end else begin
                            state_q  <= ST_ACCESS;
                            cnt_q    <= '0;
                            dm_req_q <= 1'b1;
                            we_q     <= mem_write;
                            addr_q   <= addr_d;
                            funct3_q <= funct3;
                            sdata_q  <= store_data;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dm_ack) begin
                        state_q     <= ST_RESP;
                        dm_req_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        fault_q     <= 1'b0;
                        load_data_q <= we_q ? 32'h0 : ld_w;
                    end else if (cnt_q == CNT_LAST) begin
                        // Memory never answered: drop the request and report a bus fault.
                        state_q     <= ST_RESP;
                        dm_req_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        fault_q     <= 1'b1;
                        load_data_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    fault_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    dm_req_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    fault_q     <= 1'b0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus fields are only driven while a request is outstanding.
    assign req_ready = req_ready_q;
    assign dm_req    = dm_req_q;
    assign dm_we     = dm_req_q & we_q;
    assign dm_addr   = dm_req_q ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dm_be     = dm_req_q ? be_w : 4'b0000;
    assign dm_wdata  = dm_req_q ? wdata_w : 32'h0;
    assign rsp_valid = rsp_valid_q;
    assign fault     = fault_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Each op is driven through a task that records the first bus beat, request length,
// latency and the response; expected values are hand-computed constants.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        rsp_valid;
    logic [31:0] load_data;
    logic        fault;

    int checks = 0;
    int errors = 0;

    // Values captured by run_op
    logic        got_req;
    logic        got_rsp;
    int          req_cycles;
    int          lat;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic        cap_fault;
    logic [31:0] cap_ld;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_be      (dm_be),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .rsp_valid  (rsp_valid),
        .load_data  (load_data),
        .fault      (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ack_after: number of dm_req cycles that pass before dm_ack is raised (-1 = never).
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int ack_after, input logic [31:0] rdata);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        dm_rdata   = rdata;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        got_req    = 1'b0;
        got_rsp    = 1'b0;
        req_cycles = 0;
        lat        = 1;
        cap_addr   = '0;
        cap_wdata  = '0;
        cap_be     = '0;
        cap_we     = 1'b0;
        cap_fault  = 1'b0;
        cap_ld     = '0;
        for (int i = 0; i < 40 && !got_rsp; i++) begin
            if (rsp_valid) begin
                got_rsp   = 1'b1;
                cap_fault = fault;
                cap_ld    = load_data;
            end else begin
                if (dm_req) begin
                    if (!got_req) begin
                        cap_addr  = dm_addr;
                        cap_wdata = dm_wdata;
                        cap_be    = dm_be;
                        cap_we    = dm_we;
                    end
                    got_req = 1'b1;
                    if (req_cycles == ack_after) dm_ack = 1'b1;
                    req_cycles++;
                end
                step();
                dm_ack = 1'b0;
                lat++;
            end
        end
        chk("rsp_seen", {31'h0, got_rsp}, 32'h1);
        // Response is a single-cycle pulse and the unit is ready again afterwards.
        step();
        chk("rsp_pulse_end", {31'h0, rsp_valid}, 32'h0);
        chk("ready_after", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = '0;
        store_data = '0;
        dm_rdata   = '0;
        dm_ack     = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
        chk("rst_dm_be", {28'h0, dm_be}, 32'h0);
        chk("rst_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_ld", load_data, 32'h0);
        rst_n = 1'b1;
        step();
        chk("ready_post_rst", {31'h0, req_ready}, 32'h1);

        // dm_ack while idle is ignored
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        chk("ack_idle_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("ack_idle_req", {31'h0, dm_req}, 32'h0);

        // SW 0x4, one wait cycle
        run_op(1'b0, 1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 1, 32'h0);
        chk("sw_addr", cap_addr, 32'h4);
        chk("sw_be", {28'h0, cap_be}, 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_we", {31'h0, cap_we}, 32'h1);
        chk("sw_reqcyc", req_cycles, 2);
        chk("sw_lat", lat, 3);
        chk("sw_fault", {31'h0, cap_fault}, 32'h0);
        chk("sw_ld", cap_ld, 32'h0);

        // LB 0x5 -> lane 1 = 0xBE sign-extended, minimum latency
        run_op(1'b1, 1'b0, 3'b000, 32'h5, 32'h0, 0, 32'hDEADBEEF);
        chk("lb_addr", cap_addr, 32'h4);
        chk("lb_be", {28'h0, cap_be}, 32'h2);
        chk("lb_we", {31'h0, cap_we}, 32'h0);
        chk("lb_lat", lat, 2);
        chk("lb_ld", cap_ld, 32'hFFFFFFBE);
        step();
        step();
        chk("lb_ld_hold", load_data, 32'hFFFFFFBE);

        // LBU 0x5
        run_op(1'b1, 1'b0, 3'b100, 32'h5, 32'h0, 0, 32'hDEADBEEF);
        chk("lbu_ld", cap_ld, 32'h000000BE);
        chk("lbu_fault", {31'h0, cap_fault}, 32'h0);

        // SH 0x6
        run_op(1'b0, 1'b1, 3'b001, 32'h6, 32'h00001234, 0, 32'h0);
        chk("sh_be", {28'h0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'h12341234);
        chk("sh_addr", cap_addr, 32'h4);

        // LHU 0x6 reads back the stored half
        run_op(1'b1, 1'b0, 3'b101, 32'h6, 32'h0, 0, 32'h12341234);
        chk("lhu_ld", cap_ld, 32'h00001234);

        // LH 0x6 negative half
        run_op(1'b1, 1'b0, 3'b001, 32'h6, 32'h0, 2, 32'h80010000);
        chk("lh_ld", cap_ld, 32'hFFFF8001);
        chk("lh_lat", lat, 4);

        // SB 0x3
        run_op(1'b0, 1'b1, 3'b000, 32'h3, 32'h000000A5, 0, 32'h0);
        chk("sb_be", {28'h0, cap_be}, 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("sb_addr", cap_addr, 32'h0);

        // LW 0x2 misaligned
        run_op(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_fault", {31'h0, cap_fault}, 32'h1);
        chk("lw_mis_noreq", {31'h0, got_req}, 32'h0);
        chk("lw_mis_ld", cap_ld, 32'h0);
`else
        chk("lw_mis_fault", {31'h0, cap_fault}, 32'h0);
        chk("lw_mis_addr", cap_addr, 32'h0);
        chk("lw_mis_be", {28'h0, cap_be}, 32'hF);
        chk("lw_mis_ld", cap_ld, 32'hCAFEF00D);
`endif

        // No-op
        run_op(1'b0, 1'b0, 3'b010, 32'h8, 32'h0, 0, 32'h0);
        chk("nop_noreq", {31'h0, got_req}, 32'h0);
        chk("nop_fault", {31'h0, cap_fault}, 32'h0);
        chk("nop_ld", cap_ld, 32'h0);
        chk("nop_lat", lat, 1);

        // Refill load_data so a later fault visibly clears it
        run_op(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 0, 32'h11223344);
        chk("lw_ld", cap_ld, 32'h11223344);

        // Both read and write: illegal
        run_op(1'b1, 1'b1, 3'b010, 32'h8, 32'h0, 0, 32'h0);
        chk("both_fault", {31'h0, cap_fault}, 32'h1);
        chk("both_noreq", {31'h0, got_req}, 32'h0);
        chk("both_ld", cap_ld, 32'h0);

        // Undefined funct3 on a load, unsigned size on a store
        run_op(1'b1, 1'b0, 3'b011, 32'h8, 32'h0, 0, 32'h0);
        chk("f3_011_fault", {31'h0, cap_fault}, 32'h1);
        chk("f3_011_noreq", {31'h0, got_req}, 32'h0);
        run_op(1'b0, 1'b1, 3'b100, 32'h8, 32'h0, 0, 32'h0);
        chk("sbu_fault", {31'h0, cap_fault}, 32'h1);
        chk("sbu_noreq", {31'h0, got_req}, 32'h0);

        // LW with no ack: 16 request cycles, then bus fault
        run_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, -1, 32'h0);
        chk("to_reqcyc", req_cycles, 16);
        chk("to_lat", lat, 17);
        chk("to_fault", {31'h0, cap_fault}, 32'h1);
        chk("to_ld", cap_ld, 32'h0);

        // Reset during ACCESS aborts the op
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h20;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        mem_read  = 1'b0;
        step();
        chk("abort_in_access", {31'h0, dm_req}, 32'h1);
        rst_n = 1'b0;
        step();
        chk("abort_dm_req", {31'h0, dm_req}, 32'h0);
        chk("abort_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b1;
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        chk("abort_idle_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
        step();
        chk("abort_no_rsp2", {31'h0, rsp_valid}, 32'h0);
        chk("abort_no_req", {31'h0, dm_req}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum number of cycles to wait for dm_ack before a bus fault.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  execute stage presents a memory op; req_ready  out  1  unit can accept.
REQ-005 mem_read, mem_write  in  1 each  from control_unit; both 0 = no memory op; both 1 = illegal.
REQ-006 funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  in  32  effective byte address (ALU result); store_data  in  32  rs2 value.
REQ-008 dm_req  out  1; dm_we  out  1; dm_addr  out  32 word-aligned; dm_wdata  out  32 lane-shifted; dm_be  out  4 byte enables; dm_rdata  in  32; dm_ack  in  1  data-memory side.
REQ-009 rsp_valid  out  1  one-cycle completion pulse; load_data  out  32  extended load result; fault  out  1  valid with rsp_valid.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-011 IDLE: on req_valid with exactly one of mem_read or mem_write set, SHALL latch addr, funct3, store_data and op, then go to ACCESS next cycle.
REQ-012 IDLE: req_valid with neither mem_read nor mem_write SHALL be accepted and complete as a no-op (RESP, fault=0, load_data=0) without asserting dm_req.
REQ-013 IDLE: req_valid with both mem_read and mem_write set, or with an undefined funct3 (011, 110, 111, or 1xx on store), SHALL go to RESP with fault=1 and no dm_req.
REQ-014 ACCESS: dm_req SHALL be held at 1, with dm_addr={addr[31:2],2'b00} and dm_we/dm_be/dm_wdata stable, until dm_ack is sampled at 1; RESP follows on the next cycle.
REQ-015 dm_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; dm_wdata SHALL replicate the low byte or half across lanes.
REQ-016 Loads SHALL select the byte or half of dm_rdata addressed by addr[1:0], sign-extend it for LB/LH and zero-extend it for LBU/LHU, and register it on the ack cycle.
REQ-017 A wait counter SHALL count ACCESS cycles; if TIMEOUT_CYC cycles elapse without dm_ack, the unit SHALL drop dm_req and go to RESP with fault=1.
REQ-018 RESP: rsp_valid=1 for exactly one cycle, then IDLE; minimum latency from acceptance to rsp_valid = 2 cycles plus memory wait cycles.
REQ-019 dm_ack SHALL be ignored outside ACCESS.
REQ-020 load_data SHALL hold its value until the next RESP; it is 0 for stores and faults.

Reset
REQ-021 While rst_n=0 at a clk edge: state=IDLE, counter=0, req_ready=0 during reset and 1 after, all other outputs=0.
REQ-022 Reset asserted in ACCESS or RESP SHALL abort the operation immediately: no rsp_valid is produced and dm_req is 0 on the next cycle.

Configuration
REQ-023 Macro LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL go from IDLE to RESP with fault=1 and no dm_req.
REQ-024 Macro LSU_MISALIGN_TRAP_EN undefined: the misaligned low address bits SHALL be forced to 0 (half: addr[0]; word: addr[1:0]) and the access performed normally with no fault.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the funct3 size/sign constants, and the load/store opcode constants used by control_unit.
REQ-026 One combinational sub-module, lsu_align, SHALL generate dm_be and dm_wdata and perform load extraction/extension; the FSM and counter SHALL remain in the top module.

Verification
REQ-027 SW addr=0x4, data=0xDEADBEEF, ack after 1 cycle -> dm_addr=0x4, dm_be=1111, dm_wdata=0xDEADBEEF, rsp_valid with fault=0.
REQ-028 LB addr=0x5 with dm_rdata=0xDEADBEEF -> load_data=0xFFFFFFBE; LBU at the same address -> 0x000000BE.
REQ-029 SH addr=0x6, data=0x00001234 -> dm_be=1100, dm_wdata=0x12341234; LHU addr=0x6 then returns 0x00001234.
REQ-030 LW addr=0x2 -> with LSU_MISALIGN_TRAP_EN: fault=1, no dm_req; without it: dm_addr=0x0, fault=0.
REQ-031 LW with dm_ack never asserted -> dm_req dropped after 16 cycles, rsp_valid with fault=1; rst_n pulsed mid-ACCESS -> no rsp_valid, state IDLE.
